// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Definitions shared by the byte FIFO and the pipeline stage it feeds.
//   RV_WIDTH  : width of one data word on the ready/valid link
//   rv_data_t : one data word on the ready/valid link
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int RV_WIDTH = 8;

  typedef logic [RV_WIDTH-1:0] rv_data_t;

endpackage : rv_pkg

// File: rtl/rv_fifo_mem.sv
// ---------------------------------------------------------------------------
// rv_fifo_mem
// DEPTH x WIDTH register array. It has one synchronous write port and one
// asynchronous read port.
// Ports:
//   clock : write clock
//   we    : write enable, samples wdata into entry waddr
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read of entry raddr
// ---------------------------------------------------------------------------
module rv_fifo_mem #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset. The pointers and count in the parent decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : rv_fifo_mem

// File: rtl/rv_fifo.sv
// ---------------------------------------------------------------------------
// rv_fifo
// First-word-fall-through ready/valid FIFO. It absorbs producer bursts and
// holds the head word stable until the slow downstream stage accepts it.
// The block also reports its occupancy and a high-water mark for debug.
// Ports:
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   data         : write data from the producer
//   data_valid   : the producer offers data
//   data_ready   : the FIFO accepts a word this cycle (registered state only)
//   result       : head entry; reads zero when the FIFO is empty
//   result_valid : the head entry is valid
//   result_ready : the downstream stage takes the head entry
//   level        : current occupancy, 0..DEPTH
//   high_water   : maximum occupancy since reset
// ---------------------------------------------------------------------------
module rv_fifo
  import rv_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = RV_WIDTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CW-1:0]    level,
  output logic [CW-1:0]    high_water
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_high_water;
  logic [CW-1:0]    w_count_next;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  // Both flags come from registered state only. When the FIFO is full, a pop
  // in the same cycle does not open a slot for a push.
  assign data_ready   = (r_count != FULL_COUNT);
  assign result_valid = (r_count != '0);

  assign w_push = data_valid && data_ready;
  assign w_pop  = result_valid && result_ready;

  // NOTE: the default assignment comes first so that every path drives the
  // signal and no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // sees the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_high_water <= '0;
    end else begin
      // The pointers are exactly AW bits wide, so they wrap modulo DEPTH.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      if (w_count_next > r_high_water) begin
        r_high_water <= w_count_next;
      end
    end
  end

  // No write is committed while reset is asserted. A push sampled in the
  // reset cycle is discarded along with the rest of the contents.
  rv_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (w_push && !reset),
    .waddr (r_wr_ptr),
    .wdata (data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign result     = result_valid ? w_rdata : '0;
  assign level      = r_count;
  assign high_water = r_high_water;

endmodule : rv_fifo

// File: tb/tb_rv_fifo.sv
// ---------------------------------------------------------------------------
// tb_rv_fifo
// Self-checking bench for rv_fifo (DEPTH=4, WIDTH=8). A queue-based model
// tracks the expected contents. Every negative clock edge compares all DUT
// outputs against that model. Directed scenarios add literal expectations
// that pin the model, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_rv_fifo;
  import rv_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = RV_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  rv_data_t      data;
  logic          data_valid;
  logic          data_ready;
  rv_data_t      result;
  logic          result_valid;
  logic          result_ready;
  logic [CW-1:0] level;
  logic [CW-1:0] high_water;

  rv_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .level        (level),
    .high_water   (high_water)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: a queue of words plus the largest size seen so far.
  rv_data_t m_q[$];
  int       m_hw = 0;
  bit       m_push;
  bit       m_pop;

  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_hw = 0;
    end else begin
      m_push = data_valid && (m_q.size() < DEPTH);
      m_pop  = result_ready && (m_q.size() > 0);
      if (m_pop)  void'(m_q.pop_front());
      if (m_push) m_q.push_back(data);
      if (m_q.size() > m_hw) m_hw = m_q.size();
    end
  end

  // Compare every cycle once the first reset edge has defined the state.
  bit cmp_en = 1'b0;

  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      check("m.data_ready",   32'(data_ready),   32'(m_q.size() != DEPTH));
      check("m.result_valid", 32'(result_valid), 32'(m_q.size() != 0));
      check("m.result",       32'(result),       (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      check("m.level",        32'(level),        32'(m_q.size()));
      check("m.high_water",   32'(high_water),   32'(m_hw));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  rv_data_t fill_bytes  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  rv_data_t stage_bytes [3] = '{8'h05, 8'h09, 8'h0C};
  rv_data_t got[$];

  initial begin
    int k;
    int vprob;
    int rprob;
    bit pre_push;
    bit pre_pop;
    rv_data_t pre_res;

    // Reset held for two edges while the producer offers 0xAA.
    reset        = 1'b1;
    data_valid   = 1'b1;
    data         = 8'hAA;
    result_ready = 1'b0;
    @(posedge clock);
    cmp_en = 1'b1;
    #1;
    tick();
    check("rst.level",        32'(level),        32'd0);
    check("rst.result_valid", 32'(result_valid), 32'd0);
    check("rst.result",       32'(result),       32'h00);
    check("rst.data_ready",   32'(data_ready),   32'd1);
    check("rst.high_water",   32'(high_water),   32'd0);
    reset = 1'b0;

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      data = fill_bytes[i];
      tick();
    end
    check("fill.data_ready", 32'(data_ready), 32'd0);
    check("fill.level",      32'(level),      32'd4);
    check("fill.high_water", 32'(high_water), 32'd4);
    check("fill.head",       32'(result),     32'h11);

    // A fifth byte stays on offer and is not accepted.
    data = 8'h55;
    tick();
    tick();
    check("hold.level", 32'(level),  32'd4);
    check("hold.head",  32'(result), 32'h11);

    // At full, push and pop together: only the pop happens.
    result_ready = 1'b1;
    tick();
    check("fullpp.level",      32'(level),      32'd3);
    check("fullpp.head",       32'(result),     32'h22);
    check("fullpp.data_ready", 32'(data_ready), 32'd1);
    tick();  // 0x55 is accepted here while 0x22 drains
    check("accept55.level", 32'(level),  32'd3);
    check("accept55.head",  32'(result), 32'h33);
    data_valid = 1'b0;
    tick();
    check("drain.head44", 32'(result), 32'h44);
    tick();
    check("drain.head55", 32'(result), 32'h55);
    tick();
    check("drain.empty_valid",  32'(result_valid), 32'd0);
    check("drain.empty_result", 32'(result),       32'h00);
    result_ready = 1'b0;

    // Streaming after a fresh reset: level stays at 1 and each byte appears
    // one cycle after its push.
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    data_valid   = 1'b1;
    result_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data = rv_data_t'(i);
      tick();
      check("stream.result", 32'(result), 32'(i));
      check("stream.level",  32'(level),  32'd1);
    end
    check("stream.high_water", 32'(high_water), 32'd1);
    data_valid = 1'b0;
    tick();

    // Slow pipeline stage that is ready about one cycle in sixteen.
    k = 0;
    got.delete();
    for (int cyc = 0; cyc < 600 && got.size() < 3; cyc++) begin
      data_valid   = (k < 3);
      data         = (k < 3) ? stage_bytes[k] : 8'h00;
      result_ready = ($urandom_range(15) == 0);
      pre_push = data_valid && data_ready;
      pre_pop  = result_valid && result_ready;
      pre_res  = result;
      tick();
      if (pre_push) k++;
      if (pre_pop)  got.push_back(pre_res);
    end
    check("stage.count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("stage.byte", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(stage_bytes[i]));
    end
    data_valid   = 1'b0;
    result_ready = 1'b0;
    tick();

    // Reset mid-stream at level 3, with a push offered during the reset cycle.
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = rv_data_t'(8'hA1 + i);
      tick();
    end
    check("mid.level3", 32'(level), 32'd3);
    reset = 1'b1;
    data  = 8'h99;
    tick();
    check("mid.level",        32'(level),        32'd0);
    check("mid.result_valid", 32'(result_valid), 32'd0);
    check("mid.result",       32'(result),       32'h00);
    check("mid.high_water",   32'(high_water),   32'd0);
    reset = 1'b0;
    data  = 8'h7E;
    tick();
    check("mid.result7E",     32'(result),       32'h7E);
    check("mid.result_valid", 32'(result_valid), 32'd1);
    check("mid.level1",       32'(level),        32'd1);
    data_valid = 1'b0;

    // Randomized traffic with phased biases. An offer that was not accepted
    // is held unchanged until it is taken.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 500) % 4)
        0:       begin vprob = 90; rprob = 10; end
        1:       begin vprob = 50; rprob = 50; end
        2:       begin vprob = 10; rprob = 90; end
        default: begin vprob = 95; rprob = 6;  end
      endcase
      if (!(data_valid && !data_ready)) begin
        data_valid = ($urandom_range(99) < vprob);
        data       = rv_data_t'($urandom);
      end
      result_ready = ($urandom_range(99) < rprob);
      reset        = ($urandom_range(299) == 0);
      tick();
    end
    reset        = 1'b0;
    data_valid   = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rv_fifo

// File: doc/rv_fifo.md
# rv_fifo

Ready/valid FIFO that buffers bytes from the input source and feeds the pipeline stage's `data`/`data_valid`/`data_ready` port. That stage asserts `data_ready` only about one cycle in sixteen. This block absorbs bursts from the producer and holds the head byte stable until the stage accepts it. It is first-word-fall-through with one cycle of latency, and it reports fill level and a high-water mark for debug.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `WIDTH`, default 8: data width in bits.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `data` in WIDTH: write data from the upstream producer.
- `data_valid` in 1: the producer offers `data`.
- `data_ready` out 1: the FIFO can accept a byte this cycle.
- `result` out WIDTH: head entry, connected to the pipeline stage's `data`.
- `result_valid` out 1: the head entry is valid, connected to the stage's `data_valid`.
- `result_ready` in 1: the downstream stage accepts the byte, connected to the stage's `data_ready`.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `high_water` out $clog2(DEPTH)+1: maximum `level` seen since reset.

## Operation
- push = `data_valid && data_ready`.
- pop = `result_valid && result_ready`.
- Storage: array of DEPTH words.
- Write pointer `wr_ptr` and read pointer `rd_ptr` are $clog2(DEPTH) bits each and wrap modulo DEPTH with no special case.
- Occupancy is held in `count`, which is $clog2(DEPTH)+1 bits.
- On push: `mem[wr_ptr] <= data` and `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, including when `count` is 1.
- `data_ready = (count != DEPTH)`. It depends on registered state only; there is no combinational path from `result_ready`.
- When full, a simultaneous pop does not enable a push in the same cycle.
- `result_valid = (count != 0)`.
- `result = result_valid ? mem[rd_ptr] : 0`. When empty, `result` is forced to zero.
- `level = count`.
- `high_water` rule:
  - `high_water <= max(high_water, count_next)` every cycle.
  - It is monotonic until reset and never exceeds DEPTH.
- Protocol assertions, bench-checked:
  - `data_valid` high with `data_ready` low: the producer holds `data` stable.
  - The block itself guarantees that `result` stays stable while `result_valid && !result_ready`.
- Pushes while full and pops while empty cannot occur by construction, because the enables are gated by `data_ready`/`result_valid`.

## Timing
- During reset and in the first cycle after it:
  - `count`, `wr_ptr`, `rd_ptr`, `high_water` = 0.
  - `data_ready` = 1, `result_valid` = 0, `result` = 0, `level` = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all entries in one cycle. Any push or pop sampled in the reset cycle is ignored.
- Latency:
  - A byte pushed at edge N is visible on `result`/`result_valid` in the cycle after edge N.
  - There is no bypass from `data` to `result` in the same cycle.
- Throughput: one push and one pop per cycle sustained when neither side stalls.
- Full boundary: `data_ready` falls in the cycle after the DEPTH-th push and rises in the cycle after the first pop.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.

## Structure
- Package `rv_pkg`:
  - `localparam RV_WIDTH = 8`.
  - `typedef logic [RV_WIDTH-1:0] rv_data_t`, shared with the pipeline stage.
- Sub-module `rv_fifo_mem`:
  - DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port.
  - Inputs: `clock`, `we`, `waddr`, `wdata`, `raddr`. Output: `rdata`.
  - No reset.
- Pointer, count and high-water logic live in `rv_fifo`.

## Test plan
- **Reset:** hold `reset` 2 cycles with `data_valid`=1 and `data`=0xAA → `level`=0, `result_valid`=0, `result`=0x00, `data_ready`=1, `high_water`=0.
- **Fill and drain (DEPTH=4):**
  - Push 0x11, 0x22, 0x33, 0x44 with `result_ready`=0 → `data_ready`=0 after the 4th push, `level`=4, `high_water`=4.
  - A 5th byte 0x55 is held and not accepted.
  - Set `result_ready`=1 → output 0x11, 0x22, 0x33, 0x44 in order. 0x55 is accepted the cycle after `data_ready` rises.
- **Streaming:** `data_valid` and `result_ready` held 1, `data` = 0..19 → output 0..19 each one cycle after its push, `level` constant at 1, `high_water`=1.
- **Full with simultaneous push/pop:** at `level`=4, assert `data_valid` and `result_ready` together → only the pop occurs, `level` goes to 3, and the push is accepted next cycle.
- **With pipeline stage:** connect to the stage and push 0x05, 0x09, 0x0C back-to-back → each byte is consumed only in a cycle where the stage's `data_ready`=1, and `result` holds stable between.
- **Reset mid-stream:** with `level`=3, pulse `reset` for 1 cycle → `level`=0, `result_valid`=0, `high_water`=0. Then push 0x7E → 0x7E appears on `result` next cycle.
